scan_chain_responder: RTL

//  Receiving end of the TinyTapeout scan-chain protocol driven by scan_controller.

---
 rtl/scan_chain_responder_pkg.sv | 21 ++
 rtl/scan_chain_responder_sync_edge.sv | 40 ++++
 rtl/scan_chain_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/scan_chain_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : scan_chain_responder_pkg
// Brief  : Shared defaults and sizing helpers for the scan-chain responder.
// Rev    : 1.0
// ============================================================================
package scan_chain_responder_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Edge detection stays blocked until the sync chain and its delayed copy are filled.
    function automatic int warmup_len(input int sync_stages);
        return sync_stages + 1;
    endfunction

    function automatic int frame_cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_chain_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : scan_chain_responder_sync_edge
// Brief  : Synchronizer chain with a delayed copy and rise/fall detection.
// Rev    : 1.0
// ============================================================================
module scan_chain_responder_sync_edge
    import scan_chain_responder_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_dly,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_dly  = r_dly;
    assign o_rise = o_sync & ~r_dly;
    assign o_fall = ~o_sync & r_dly;

endmodule
`default_nettype wire

// File: rtl/scan_chain_responder.sv
`default_nettype none
// ============================================================================
// Module : scan_chain_responder
// Brief  : Scan-chain receiving element: shift, capture, latch and retime.
//          Optional frame bit-count checking enabled by SCAN_FRAME_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module scan_chain_responder
    import scan_chain_responder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sc_clk_in,
    input  logic             sc_data_in,
    input  logic             sc_select_in,
    input  logic             sc_latch_in,
    output logic             sc_clk_out,
    output logic             sc_select_out,
    output logic             sc_latch_out,
    output logic             sc_data_out,
    input  logic [WIDTH-1:0] design_out,
    output logic [WIDTH-1:0] design_in,
    output logic             latch_strobe,
    output logic             frame_err
);

    localparam int WARM = warmup_len(SYNC_STAGES);
    localparam int WW   = $clog2(WARM + 1);

    // Index map: 0 = sc_clk, 1 = data, 2 = select, 3 = latch
    logic [3:0] w_async;
    logic [3:0] w_sync;
    logic [3:0] w_dly;
    logic [3:0] w_rise;
    logic [3:0] w_fall;

    assign w_async = {sc_latch_in, sc_select_in, sc_data_in, sc_clk_in};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            scan_chain_responder_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .reset  (reset),
                .i_async(w_async[gi]),
                .o_sync (w_sync[gi]),
                .o_dly  (w_dly[gi]),
                .o_rise (w_rise[gi]),
                .o_fall (w_fall[gi])
            );
        end
    endgenerate

    logic w_unused_edges;
    assign w_unused_edges = &{1'b0, w_rise[2:1], w_fall[3:1], w_sync[3], w_sync[0], w_dly[1]};

    assign sc_clk_out    = w_dly[0];
    assign sc_select_out = w_dly[2];
    assign sc_latch_out  = w_dly[3];

    logic [WW-1:0]    r_warm;
    logic             w_en;
    logic             w_clk_rise;
    logic             w_clk_fall;
    logic             w_latch_rise;
    logic [WIDTH-1:0] r_shift;

    assign w_en         = (r_warm == WW'(WARM));
    assign w_clk_rise   = w_en & w_rise[0];
    assign w_clk_fall   = w_en & w_fall[0];
    assign w_latch_rise = w_en & w_rise[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm       <= '0;
            r_shift      <= '0;
            design_in    <= '0;
            sc_data_out  <= 1'b0;
            latch_strobe <= 1'b0;
        end else begin
            latch_strobe <= 1'b0;
            if (!w_en) begin
                r_warm <= r_warm + 1'b1;
            end
            // Latch reads the pre-shift value when it coincides with a clock rise.
            if (w_latch_rise) begin
                design_in    <= r_shift;
                latch_strobe <= 1'b1;
            end
            if (w_clk_rise) begin
                if (w_sync[2]) begin
                    r_shift <= design_out;
                end else begin
                    r_shift <= {w_sync[1], r_shift[WIDTH-1:1]};
                end
            end
            if (w_clk_fall) begin
                sc_data_out <= r_shift[0];
            end
        end
    end

`ifdef SCAN_FRAME_CHECK_EN
    localparam int CW = frame_cnt_width(WIDTH);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            frame_err <= 1'b0;
        end else if (w_latch_rise) begin
            frame_err <= (r_cnt != CW'(WIDTH));
            r_cnt     <= '0;
        end else if (w_clk_rise) begin
            if (w_sync[2]) begin
                r_cnt <= '0;
            end else if (r_cnt != CW'(2 * WIDTH - 1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire
